// File: rtl/storage_exc_ctrl.sv
// Storage-exception controller: per-channel MMU permission check, first-fault ISI/DSI capture.
// Optional TLB-miss reporting (entry_hit, itlb_miss, dtlb_miss) when STORAGE_EXC_MISS_EN is defined.

`ifndef MSR_PR
`define MSR_PR 17
`endif

module storage_exc_ctrl #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int CH_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:31]             MSR,
  input  logic [NCH-1:0]          acc_vld,
  input  logic [NCH-1:0]          acc_fetch,
  input  logic [NCH-1:0]          acc_load,
  input  logic [NCH-1:0]          acc_store,
  input  logic [NCH*ADDR_W-1:0]   acc_addr,
  input  logic [NCH*6-1:0]        entry_perm,
`ifdef STORAGE_EXC_MISS_EN
  input  logic [NCH-1:0]          entry_hit,
  output logic                    itlb_miss,
  output logic                    dtlb_miss,
`endif
  input  logic                    ack,
  output logic                    isi,
  output logic                    dsi,
  output logic [ADDR_W-1:0]       exc_addr,
  output logic [CH_W-1:0]         exc_ch,
  output logic                    exc_st,
  output logic                    exc_ovf
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                isi_q, isi_d;
  logic                dsi_q, dsi_d;
  logic                st_q, st_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
`ifdef STORAGE_EXC_MISS_EN
  logic                itlb_q, itlb_d;
  logic                dtlb_q, dtlb_d;
`endif

  logic                pr_s;
  logic [0:31]         msr_unused_s;
  logic [NCH-1:0]      hit_s;
  logic [NCH-1:0]      xv_s, wv_s, rv_s, mv_s, ev_s, oh_s;
  logic                any_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [CH_W-1:0]     win_ch_s;
  logic                win_fetch_s, win_store_s, win_miss_s;
  logic                cap_s, clr_s;

  assign pr_s         = MSR[`MSR_PR];
  assign msr_unused_s = MSR;

`ifdef STORAGE_EXC_MISS_EN
  assign hit_s = entry_hit;
`else
  assign hit_s = {NCH{1'b1}};
`endif

  // Per-channel violation detect; perm layout per channel is {UX,SX,UR,SR,UW,SW}
  always_comb begin
    xv_s = '0;
    wv_s = '0;
    rv_s = '0;
    mv_s = '0;
    for (int i = 0; i < NCH; i++) begin
      mv_s[i] = acc_vld[i] & ~hit_s[i] & (acc_fetch[i] | acc_load[i] | acc_store[i]);
      xv_s[i] = acc_vld[i] & hit_s[i] & acc_fetch[i]
              & ~(pr_s ? entry_perm[i*6+5] : entry_perm[i*6+4]);
      wv_s[i] = acc_vld[i] & hit_s[i] & acc_store[i]
              & ~(pr_s ? entry_perm[i*6+1] : entry_perm[i*6+0]);
      rv_s[i] = acc_vld[i] & hit_s[i] & acc_load[i]
              & ~(pr_s ? entry_perm[i*6+3] : entry_perm[i*6+2]);
    end
  end

  assign ev_s  = xv_s | wv_s | rv_s | mv_s;
  assign oh_s  = ev_s & (~ev_s + NCH'(1));
  assign any_s = |ev_s;

  // Select the syndrome of the lowest-index faulting channel (one-hot AND-OR mux)
  always_comb begin
    win_addr_s  = '0;
    win_ch_s    = '0;
    win_fetch_s = 1'b0;
    win_store_s = 1'b0;
    win_miss_s  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      win_addr_s  = win_addr_s | ({ADDR_W{oh_s[i]}} & acc_addr[i*ADDR_W +: ADDR_W]);
      win_ch_s    = win_ch_s | ({CH_W{oh_s[i]}} & CH_W'(i));
      win_miss_s  = win_miss_s | (oh_s[i] & mv_s[i]);
      win_fetch_s = win_fetch_s | (oh_s[i] & (mv_s[i] ? acc_fetch[i] : xv_s[i]));
      win_store_s = win_store_s | (oh_s[i] & (mv_s[i] ? (~acc_fetch[i] & acc_store[i])
                                                      : (~xv_s[i] & wv_s[i])));
    end
  end

  // Next-state logic; an ack coinciding with a new fault re-captures without idling
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    cap_s   = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d = PEND;
          cap_s   = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (ack) begin
          ovf_d = 1'b0;
          if (any_s) begin
            state_d = PEND;
            cap_s   = 1'b1;
          end else begin
            state_d = IDLE;
            clr_s   = 1'b1;
          end
        end else if (any_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end
      default: begin
        state_d = IDLE;
        clr_s   = 1'b1;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Pending flags and syndrome; syndrome is kept after clear
  always_comb begin
    isi_d  = isi_q;
    dsi_d  = dsi_q;
    st_d   = st_q;
    addr_d = addr_q;
    ch_d   = ch_q;
`ifdef STORAGE_EXC_MISS_EN
    itlb_d = itlb_q;
    dtlb_d = dtlb_q;
`endif
    if (cap_s) begin
      isi_d  = ~win_miss_s & win_fetch_s;
      dsi_d  = ~win_miss_s & ~win_fetch_s;
      st_d   = win_store_s;
      addr_d = win_addr_s;
      ch_d   = win_ch_s;
`ifdef STORAGE_EXC_MISS_EN
      itlb_d = win_miss_s & win_fetch_s;
      dtlb_d = win_miss_s & ~win_fetch_s;
`endif
    end else if (clr_s) begin
      isi_d  = 1'b0;
      dsi_d  = 1'b0;
`ifdef STORAGE_EXC_MISS_EN
      itlb_d = 1'b0;
      dtlb_d = 1'b0;
`endif
    end else begin
      isi_d  = isi_q;
      dsi_d  = dsi_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      isi_q   <= 1'b0;
      dsi_q   <= 1'b0;
      st_q    <= 1'b0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      ch_q    <= '0;
`ifdef STORAGE_EXC_MISS_EN
      itlb_q  <= 1'b0;
      dtlb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      isi_q   <= isi_d;
      dsi_q   <= dsi_d;
      st_q    <= st_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
`ifdef STORAGE_EXC_MISS_EN
      itlb_q  <= itlb_d;
      dtlb_q  <= dtlb_d;
`endif
    end
  end

  assign isi      = isi_q;
  assign dsi      = dsi_q;
  assign exc_addr = addr_q;
  assign exc_ch   = ch_q;
  assign exc_st   = st_q;
  assign exc_ovf  = ovf_q;
`ifdef STORAGE_EXC_MISS_EN
  assign itlb_miss = itlb_q;
  assign dtlb_miss = dtlb_q;
`endif

endmodule
